sram_ctrl: RTL and testbench

- Multi-cycle SRAM bus controller between the LC-3 datapath memory port and the board's asynchronous 16-bit SRAM pins (CE, UB, LB, OE, WE, ADDR, Data).
- Accepts one read or write request at a time and sequences the active-low strobes with programmable wait states.
- Owns the bidirectional Data bus and returns read data plus a one-cycle completion pulse, so the CPU state machine does not count memory cycles itself.

---
 rtl/sram_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: multi-cycle controller between the LC-3 memory port and an
// asynchronous 16-bit SRAM. One access at a time; strobes, address and the
// data-bus enable are all registered so no request input reaches a pin
// combinationally.
//
// Request handshake: req is a single-cycle-or-held strobe that is only
// looked at while the controller is IDLE (busy=0). The access is accepted on
// the clock edge where IDLE and req=1 coincide; busy then stays high until
// the controller returns to IDLE, and done pulses for exactly one cycle in
// the DONE state. A req seen in any other state is dropped, not queued.
module sram_ctrl #(
  parameter int RD_WAIT = 2,  // cycles CE/OE held low before sampling, 1..15
  parameter int WR_WAIT = 2   // cycles WE held low, 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we_req,
  input  logic [1:0]  be,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // The counter is loaded with WAIT-1 and the phase ends when it reads zero,
  // so a phase spans exactly WAIT cycles.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;
  logic [19:0] addr_q;
  logic [15:0] rdata_q;
  logic [15:0] rdata_d;
  logic        done_q;
  logic        busy_q;
  logic        ce_q;
  logic        ub_q;
  logic        lb_q;
  logic        oe_q;
  logic        we_q;
  logic        drive_q;

  // Read capture value: lanes that were not enabled read back as zero rather
  // than whatever happens to be floating on the bus.
  always_comb begin
    rdata_d = {be_q[1] ? Data[15:8] : 8'h00,
               be_q[0] ? Data[7:0]  : 8'h00};
  end

  // Controller FSM; every pin-facing output is set on the edge entering the
  // state it belongs to, so each state's outputs are valid for its whole span.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      addr_q  <= 20'h00000;
      rdata_q <= 16'h0000;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ce_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            busy_q  <= 1'b1;
            ce_q    <= 1'b0;
            ub_q    <= ~be[1];
            lb_q    <= ~be[0];
            if (we_req) begin
              state_q <= S_WR_SETUP;
              cnt_q   <= WR_LOAD;
              drive_q <= 1'b1;
            end else begin
              state_q <= S_RD;
              cnt_q   <= RD_LOAD;
              oe_q    <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            rdata_q <= rdata_d;
            done_q  <= 1'b1;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WR_SETUP: begin
          state_q <= S_WR_PULSE;
          we_q    <= 1'b0;
        end
        S_WR_PULSE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_WR_HOLD;
            we_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WR_HOLD: begin
          // Data stays driven through this cycle so it is held past WE rising.
          state_q <= S_DONE;
          done_q  <= 1'b1;
          drive_q <= 1'b0;
          ce_q    <= 1'b1;
          ub_q    <= 1'b1;
          lb_q    <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ce_q    <= 1'b1;
          ub_q    <= 1'b1;
          lb_q    <= 1'b1;
          oe_q    <= 1'b1;
          we_q    <= 1'b1;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign Data        = drive_q ? wdata_q : 16'hzzzz;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign CE          = ce_q;
  assign UB          = ub_q;
  assign LB          = lb_q;
  assign OE          = oe_q;
  assign WE          = we_q;
  assign ADDR        = addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl. Instance 0 uses the default
// wait states, instance 1 uses RD_WAIT=1 / WR_WAIT=4. Each instance talks to
// its own small asynchronous SRAM model.
module tb_sram_ctrl;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // ---------------- shared request inputs ----------------
  logic        req0, req1;
  logic        we_req;
  logic [1:0]  be;
  logic [19:0] addr;
  logic [15:0] wdata;

  // ---------------- instance 0 (defaults) ----------------
  logic [15:0] rdata0;
  logic        done0, busy0, ce0, ub0, lb0, oe0, we0;
  logic [19:0] adr0;
  wire  [15:0] data0;
  logic [2:0]  st0;

  sram_ctrl u_dut0 (
    .Clk(Clk), .Reset(Reset), .req(req0), .we_req(we_req), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .done(done0), .busy(busy0),
    .CE(ce0), .UB(ub0), .LB(lb0), .OE(oe0), .WE(we0), .ADDR(adr0),
    .Data(data0), .dbg_state_o(st0)
  );

  // ---------------- instance 1 (RD_WAIT=1, WR_WAIT=4) ----------------
  logic [15:0] rdata1;
  logic        done1, busy1, ce1, ub1, lb1, oe1, we1;
  logic [19:0] adr1;
  wire  [15:0] data1;
  logic [2:0]  st1;

  sram_ctrl #(.RD_WAIT(1), .WR_WAIT(4)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .req(req1), .we_req(we_req), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .done(done1), .busy(busy1),
    .CE(ce1), .UB(ub1), .LB(lb1), .OE(oe1), .WE(we1), .ADDR(adr1),
    .Data(data1), .dbg_state_o(st1)
  );

  // ---------------- SRAM models ----------------
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  assign data0 = (!ce0 && !oe0 && we0) ? mem0[adr0[7:0]] : 16'hzzzz;
  assign data1 = (!ce1 && !oe1 && we1) ? mem1[adr1[7:0]] : 16'hzzzz;

  always @(posedge we0) begin
    if (!ce0) begin
      if (!ub0) mem0[adr0[7:0]][15:8] <= data0[15:8];
      if (!lb0) mem0[adr0[7:0]][7:0]  <= data0[7:0];
    end
  end

  always @(posedge we1) begin
    if (!ce1) begin
      if (!ub1) mem1[adr1[7:0]][15:8] <= data1[15:8];
      if (!lb1) mem1[adr1[7:0]][7:0]  <= data1[7:0];
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver: one complete access ----------------
  task automatic do_access(input int inst, input logic w, input logic [1:0] b,
                           input logic [19:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd, input string tag);
    int rw, ww, lat, oe_lo, we_lo, both_lo, data_bad;
    logic seen;
    logic [2:0]  pins_c1;
    logic [19:0] addr_c1;
    logic s_done, s_oe, s_we;
    logic [15:0] s_data;
    rw = (inst != 0) ? 1 : 2;
    ww = (inst != 0) ? 4 : 2;
    lat = 0; oe_lo = 0; we_lo = 0; both_lo = 0; data_bad = 0; seen = 1'b0;
    pins_c1 = 3'b111; addr_c1 = 20'h0;
    @(negedge Clk);
    we_req = w; be = b; addr = a; wdata = d;
    if (inst != 0) req1 = 1'b1; else req0 = 1'b1;
    @(posedge Clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      s_done = (inst != 0) ? done1 : done0;
      s_oe   = (inst != 0) ? oe1   : oe0;
      s_we   = (inst != 0) ? we1   : we0;
      s_data = (inst != 0) ? data1 : data0;
      if (c == 1) begin
        pins_c1 = (inst != 0) ? {ce1, ub1, lb1} : {ce0, ub0, lb0};
        addr_c1 = (inst != 0) ? adr1 : adr0;
      end
      if (!s_oe) oe_lo++;
      if (!s_we) we_lo++;
      if (!s_oe && !s_we) both_lo++;
      if (w && c <= ww + 2 && s_data !== d) data_bad++;
      if (s_done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        @(posedge Clk); #1;
      end
    end
    check({tag, "_latency"}, lat, w ? ww + 3 : rw + 1);
    check({tag, "_oe_low_cycles"}, oe_lo, w ? 0 : rw);
    check({tag, "_we_low_cycles"}, we_lo, w ? ww : 0);
    check({tag, "_oe_we_overlap"}, both_lo, 0);
    check({tag, "_ce_ub_lb"}, pins_c1, {1'b0, ~b});
    check({tag, "_addr"}, addr_c1, a);
    if (w) check({tag, "_data_drive"}, data_bad, 0);
    check({tag, "_rdata_at_done"}, (inst != 0) ? rdata1 : rdata0, exp_rd);
    @(posedge Clk); #1;
    check({tag, "_done_pulse_1cyc"}, (inst != 0) ? done1 : done0, 0);
    check({tag, "_idle_busy"}, (inst != 0) ? busy1 : busy0, 0);
    check({tag, "_rdata_hold"}, (inst != 0) ? rdata1 : rdata0, exp_rd);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        w;
    logic [1:0]  b;
    logic [19:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[12];
  logic [15:0] last_rd0;
  logic [15:0] last_rd1;

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [15:0] exp_rd;
    int   k, ndone, both_lo, busy_seen;
    int   acc[4];
    logic [15:0] rd_got[4];
    logic bw[4];
    logic [19:0] ba[4];
    logic [15:0] bd[4];
    logic prev_busy, seen;

    vt[0]  = '{1'b1, 2'b11, 20'h00012, 16'h1111, 16'h0000};
    vt[1]  = '{1'b1, 2'b11, 20'h00003, 16'h1234, 16'h0000};
    vt[2]  = '{1'b0, 2'b11, 20'h00003, 16'h0000, 16'h1234};
    vt[3]  = '{1'b0, 2'b01, 20'h00003, 16'h0000, 16'h0034};
    vt[4]  = '{1'b0, 2'b10, 20'h00003, 16'h0000, 16'h1200};
    vt[5]  = '{1'b1, 2'b01, 20'h00012, 16'hABCD, 16'h0000};
    vt[6]  = '{1'b0, 2'b11, 20'h00012, 16'h0000, 16'h11CD};
    vt[7]  = '{1'b1, 2'b00, 20'h00012, 16'h5555, 16'h0000};
    vt[8]  = '{1'b0, 2'b00, 20'h00012, 16'h0000, 16'h0000};
    vt[9]  = '{1'b0, 2'b11, 20'h00012, 16'h0000, 16'h11CD};
    vt[10] = '{1'b1, 2'b10, 20'h00012, 16'hBEEF, 16'h0000};
    vt[11] = '{1'b0, 2'b11, 20'h00012, 16'h0000, 16'hBECD};

    req0 = 1'b0; req1 = 1'b0; we_req = 1'b0; be = 2'b00;
    addr = 20'h0; wdata = 16'h0;
    last_rd0 = 16'h0000; last_rd1 = 16'h0000;

    // Power-on reset
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst0_strobes", {ce0, oe0, we0, ub0, lb0}, 5'b11111);
    check("rst0_busy_done", {busy0, done0}, 2'b00);
    check("rst0_rdata", rdata0, 16'h0000);
    check("rst0_addr", adr0, 20'h0);
    check("rst0_state", st0, 3'd0);
    check("rst1_strobes", {ce1, oe1, we1, ub1, lb1}, 5'b11111);
    check("rst1_busy_rdata", {busy1, rdata1}, 17'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // Table-driven accesses on the default instance
    for (int i = 0; i < 12; i++) begin
      exp_rd = vt[i].w ? last_rd0 : vt[i].exp;
      do_access(0, vt[i].w, vt[i].b, vt[i].a, vt[i].d, exp_rd, $sformatf("v%0d", i));
      last_rd0 = exp_rd;
    end

    // Reset held low two cycles in the middle of a read
    @(negedge Clk);
    we_req = 1'b0; be = 2'b11; addr = 20'h00012; req0 = 1'b1;
    @(posedge Clk); #1;
    req0 = 1'b0;
    check("midrd_in_read", {busy0, oe0}, 2'b10);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("midrd_rst_strobes", {ce0, oe0, we0, ub0, lb0}, 5'b11111);
    check("midrd_rst_rdata", rdata0, 16'h0000);
    check("midrd_rst_busy_done", {busy0, done0}, 2'b00);
    check("midrd_rst_addr", adr0, 20'h0);
    @(posedge Clk); #1;
    check("midrd_rst_hold", {busy0, ce0, oe0}, 3'b011);
    @(negedge Clk);
    Reset = 1'b1;
    last_rd0 = 16'h0000;
    do_access(0, 1'b0, 2'b11, 20'h00012, 16'h0000, 16'hBECD, "post_rst_rd");
    last_rd0 = 16'hBECD;

    // Back-to-back with req held: read, read, write, read
    bw = '{1'b0, 1'b0, 1'b1, 1'b0};
    ba = '{20'h00003, 20'h00012, 20'h00020, 20'h00020};
    bd = '{16'h0000, 16'h0000, 16'h7777, 16'h0000};
    rd_got = '{16'h0, 16'h0, 16'h0, 16'h0};
    acc = '{0, 0, 0, 0};
    k = 0; ndone = 0; both_lo = 0; prev_busy = 1'b0;
    @(negedge Clk);
    we_req = bw[0]; be = 2'b11; addr = ba[0]; wdata = bd[0]; req0 = 1'b1;
    for (int c = 1; c <= 80 && ndone < 4; c++) begin
      @(posedge Clk); #1;
      if (!oe0 && !we0) both_lo++;
      if (done0 && k > 0) begin
        rd_got[k-1] = rdata0;
        ndone++;
      end
      if (busy0 && !prev_busy && k < 4) begin
        acc[k] = c;
        k++;
        if (k < 4) begin
          we_req = bw[k]; addr = ba[k]; wdata = bd[k];
        end else begin
          req0 = 1'b0;
        end
      end
      prev_busy = busy0;
    end
    req0 = 1'b0;
    check("b2b_accepts", k, 4);
    check("b2b_dones", ndone, 4);
    check("b2b_space_rd_rd", acc[1] - acc[0], 4);
    check("b2b_space_rd_wr", acc[2] - acc[1], 4);
    check("b2b_space_wr_rd", acc[3] - acc[2], 6);
    check("b2b_rd0", rd_got[0], 16'h1234);
    check("b2b_rd1", rd_got[1], 16'hBECD);
    check("b2b_rd3", rd_got[3], 16'h7777);
    check("b2b_oe_we_overlap", both_lo, 0);

    // Short-read / long-write instance
    do_access(1, 1'b1, 2'b11, 20'h00005, 16'hC0DE, last_rd1, "w4_wr");
    do_access(1, 1'b0, 2'b11, 20'h00005, 16'h0000, 16'hC0DE, "w4_rd");
    last_rd1 = 16'hC0DE;

    // req pulsed during DONE must not start a second access
    @(negedge Clk);
    we_req = 1'b1; be = 2'b11; addr = 20'h0000A; wdata = 16'h1357; req1 = 1'b1;
    @(posedge Clk); #1;
    req1 = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (done1) seen = 1'b1;
      else begin
        @(posedge Clk); #1;
      end
    end
    check("done_req_done_seen", seen, 1'b1);
    we_req = 1'b0; addr = 20'h00005; req1 = 1'b1;
    @(posedge Clk); #1;
    req1 = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy1 || !ce1) busy_seen++;
      @(posedge Clk); #1;
    end
    check("done_req_ignored", busy_seen, 0);
    check("done_req_rdata_kept", rdata1, 16'hC0DE);
    do_access(1, 1'b0, 2'b11, 20'h0000A, 16'h0000, 16'h1357, "w4_rd_a");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
